// File: rtl/sar_feature_quantizer.sv
// sar_feature_quantizer: SAR ADC controller converting NUM_FEAT channels per frame, N-bit binary search each.
module sar_feature_quantizer #(
  parameter int N          = 4,
  parameter int SAR_CYCLES = 5,
  parameter int NUM_FEAT   = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          start_i,
  input  logic                                          abort_i,
  input  logic                                          comp_i,
  output logic                                          sample_o,
  output logic [N-1:0]                                  dac_code_o,
  output logic [$clog2(NUM_FEAT > 1 ? NUM_FEAT : 2)-1:0] ch_sel_o,
  output logic                                          busy_o,
  output logic [N-1:0]                                  quant_feat_o,
  output logic                                          feat_valid_o,
  output logic                                          frame_done_o
);
  localparam int SC  = SAR_CYCLES - N;
  localparam int CW  = $clog2(SC > 1 ? SC : 2);
  localparam int BW  = $clog2(N > 1 ? N : 2);
  localparam int CHW = $clog2(NUM_FEAT > 1 ? NUM_FEAT : 2);
  localparam logic [CHW-1:0] LAST = CHW'(NUM_FEAT - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, EMIT} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [BW-1:0]  bit_q;
  logic [N-1:0]   res_q, res_d, dac_d;
  logic           fv_q, fd_q;

  // Result with the current trial bit resolved, and the next trial code built on it.
  always_comb begin
    res_d = res_q;
    res_d[bit_q] = comp_i;
    dac_d = res_d | (N'(1) << (bit_q - BW'(1)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      res_q        <= '0;
      ch_sel_o     <= '0;
      busy_o       <= 1'b0;
      sample_o     <= 1'b0;
      dac_code_o   <= '0;
      quant_feat_o <= '0;
      fv_q         <= 1'b0;
      fd_q         <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      fd_q <= 1'b0;
      if (abort_i && state_q != IDLE) begin
        state_q    <= IDLE;
        ch_sel_o   <= '0;
        busy_o     <= 1'b0;
        sample_o   <= 1'b0;
        dac_code_o <= '0;
      end else begin
        case (state_q)
          IDLE: if (start_i && !abort_i) begin
            ch_sel_o <= '0;
            cnt_q    <= '0;
            busy_o   <= 1'b1;
            sample_o <= 1'b1;
            state_q  <= SAMPLE;
          end
          SAMPLE: if (cnt_q == CW'(SC - 1)) begin
            res_q      <= '0;
            bit_q      <= BW'(N - 1);
            sample_o   <= 1'b0;
            dac_code_o <= N'(1) << (N - 1);
            state_q    <= CONVERT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          CONVERT: begin
            res_q <= res_d;
            if (bit_q == '0) begin
              quant_feat_o <= res_d;
              dac_code_o   <= '0;
              fv_q         <= 1'b1;
              fd_q         <= (ch_sel_o == LAST);
              state_q      <= EMIT;
            end else begin
              bit_q      <= bit_q - 1'b1;
              dac_code_o <= dac_d;
            end
          end
          default: if (ch_sel_o != LAST || start_i) begin
            ch_sel_o <= (ch_sel_o == LAST) ? '0 : ch_sel_o + 1'b1;
            cnt_q    <= '0;
            sample_o <= 1'b1;
            state_q  <= SAMPLE;
          end else begin
            ch_sel_o <= '0;
            busy_o   <= 1'b0;
            state_q  <= IDLE;
          end
        endcase
      end
    end
  end

  // An abort landing on the EMIT cycle suppresses the pulse that cycle.
  assign feat_valid_o = fv_q & ~abort_i;
  assign frame_done_o = fd_q & ~abort_i;
endmodule

// File: tb/tb_sar_feature_quantizer.sv
// tb_sar_feature_quantizer: directed and random frames checked against a frame-phase reference model.
module tb_sar_feature_quantizer;
  logic       clk = 1'b0;
  logic       rst_ni, start, abort, comp;
  logic [3:0] vin [2];
  logic       sample, busy, feat_valid, frame_done;
  logic [3:0] dac_code, quant_feat;
  logic [0:0] ch_sel;
  logic [7:0] sr = '0;
  int         n_sh = 0;
  int         n_vec = 0, n_err = 0;
  int         ph = 0;
  logic [3:0] q_exp = '0;

  sar_feature_quantizer #(.N(4), .SAR_CYCLES(5), .NUM_FEAT(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .abort_i(abort), .comp_i(comp),
    .sample_o(sample), .dac_code_o(dac_code), .ch_sel_o(ch_sel), .busy_o(busy),
    .quant_feat_o(quant_feat), .feat_valid_o(feat_valid), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;
  assign comp = vin[ch_sel] >= dac_code;

  // Downstream feature_shift_reg stand-in, enabled by feat_valid.
  always @(posedge clk) if (feat_valid) begin
    sr   <= {sr[3:0], quant_feat};
    n_sh <= n_sh + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ph = cycle index within a frame (1..12), 0 when idle; each channel takes 6 cycles:
  // 1 sample, 4 trials MSB-first, 1 emit.
  task automatic check_all();
    int m, ch, b;
    logic [3:0] v, d;
    logic fv;
    m  = ph % 6;
    ch = (ph == 0) ? 0 : (ph - 1) / 6;
    v  = vin[ch];
    fv = ph != 0 && m == 0 && !abort;
    if (ph != 0 && m == 0) q_exp = v;
    d = '0;
    if (ph != 0 && m >= 2) begin
      b = 5 - m;
      d = ((v >> (b + 1)) << (b + 1)) | (4'd1 << b);
    end
    chk("busy", busy, ph != 0);
    chk("sample", sample, ph != 0 && m == 1);
    if (m != 0) chk("dac_code", dac_code, d);
    chk("ch_sel", ch_sel, ch);
    chk("feat_valid", feat_valid, fv);
    chk("frame_done", frame_done, fv && ph == 12);
    chk("quant_feat", quant_feat, q_exp);
  endtask

  task automatic cyc(input logic s, input logic a);
    start = s;
    abort = a;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (ph == 0) ph = (s && !a) ? 1 : 0;
    else if (a) ph = 0;
    else if (ph == 12) ph = s ? 1 : 0;
    else ph++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_sample", sample, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_quant", quant_feat, 0);
    chk("rst_fv", feat_valid, 0);
    chk("rst_fd", frame_done, 0);
    ph = 0;
    q_exp = '0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic frame(input logic [3:0] a0, input logic [3:0] a1);
    int n0;
    vin[0] = a0;
    vin[1] = a1;
    n0 = n_sh;
    cyc(1, 0);
    repeat (13) cyc(0, 0);
    chk("shifts", n_sh - n0, 2);
    chk("shift_reg", sr, {a0, a1});
  endtask

  initial begin
    rst_ni = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    vin[0] = '0;
    vin[1] = '0;
    #12;
    chk("init_busy", busy, 0);
    chk("init_quant", quant_feat, 0);
    chk("init_fv", feat_valid, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) cyc(0, 1);
    cyc(1, 1);
    repeat (2) cyc(0, 0);
    frame(4'b1011, 4'b0110);
    frame(4'b0000, 4'b1111);
    frame(4'b1111, 4'b0000);
    vin[0] = 4'b1001;
    vin[1] = 4'b0101;
    repeat (36) cyc(1, 0);
    repeat (4) cyc(0, 0);
    vin[0] = 4'b0111;
    cyc(1, 0);
    repeat (2) cyc(0, 0);
    cyc(0, 1);
    repeat (3) cyc(0, 0);
    frame(4'b1100, 4'b0011);
    vin[0] = 4'b1110;
    cyc(1, 0);
    repeat (2) cyc(0, 0);
    do_reset();
    repeat (14) cyc(0, 0);
    frame(4'b0101, 4'b1010);
    for (int i = 0; i < 800; i++) begin
      if (ph == 0) begin
        vin[0] = 4'($urandom);
        vin[1] = 4'($urandom);
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
